// File: rtl/data_req_rr_arbiter.sv
// Round-robin arbiter for the cache data-array request port. It supports multi-beat
// locking and drives a single registered, full-throughput output stage.
module data_req_rr_arbiter #(
   parameter int SET_W = 8,
   parameter int SEL_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_0_valid,
   output logic             io_in_0_ready,
   input  logic [SET_W-1:0] io_in_0_bits_set,
   input  logic [SEL_W-1:0] io_in_0_bits_blockSelOH,
   input  logic             io_in_0_bits_last,
   input  logic             io_in_1_valid,
   output logic             io_in_1_ready,
   input  logic [SET_W-1:0] io_in_1_bits_set,
   input  logic [SEL_W-1:0] io_in_1_bits_blockSelOH,
   input  logic             io_in_1_bits_last,
   input  logic             io_in_2_valid,
   output logic             io_in_2_ready,
   input  logic [SET_W-1:0] io_in_2_bits_set,
   input  logic [SEL_W-1:0] io_in_2_bits_blockSelOH,
   input  logic             io_in_2_bits_last,
   input  logic             io_out_ready,
   output logic             io_out_valid,
   output logic [SET_W-1:0] io_out_bits_set,
   output logic [SEL_W-1:0] io_out_bits_blockSelOH,
   output logic [1:0]       io_out_bits_chosen
);

   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   logic [3:0]       req_vld;
   logic [1:0]       ptr;
   logic             lock;
   logic [1:0]       lock_id;
   logic             en;
   logic             fire;
   logic             grant_any;
   logic [1:0]       grant_id;
   logic [1:0]       pri_1;
   logic [1:0]       pri_2;
   logic [SET_W-1:0] sel_set;
   logic [SEL_W-1:0] sel_oh;
   logic             sel_last;

   // Spare top bit keeps an out-of-range pointer from selecting a real requester.
   assign req_vld = {1'b0, io_in_2_valid, io_in_1_valid, io_in_0_valid};
   assign en      = ~io_out_valid | io_out_ready;
   assign pri_1   = rr_next(ptr);
   assign pri_2   = rr_next(pri_1);

   always_comb begin
      grant_any = 1'b0;
      grant_id  = 2'd0;
      if (lock) begin
         grant_any = req_vld[lock_id];
         grant_id  = lock_id;
      end else if (req_vld[pri_1]) begin
         grant_any = 1'b1;
         grant_id  = pri_1;
      end else if (req_vld[pri_2]) begin
         grant_any = 1'b1;
         grant_id  = pri_2;
      end else if (req_vld[ptr]) begin
         grant_any = 1'b1;
         grant_id  = ptr;
      end
   end

   assign fire          = grant_any & en;
   assign io_in_0_ready = fire & (grant_id == 2'd0);
   assign io_in_1_ready = fire & (grant_id == 2'd1);
   assign io_in_2_ready = fire & (grant_id == 2'd2);

   always_comb begin
      sel_set  = io_in_0_bits_set;
      sel_oh   = io_in_0_bits_blockSelOH;
      sel_last = io_in_0_bits_last;
      case (grant_id)
         2'd1: begin
            sel_set  = io_in_1_bits_set;
            sel_oh   = io_in_1_bits_blockSelOH;
            sel_last = io_in_1_bits_last;
         end
         2'd2: begin
            sel_set  = io_in_2_bits_set;
            sel_oh   = io_in_2_bits_blockSelOH;
            sel_last = io_in_2_bits_last;
         end
         default: ;
      endcase
   end

   // Output stage: loads on fire, empties on drain without fire, holds while stalled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_out_valid           <= 1'b0;
         io_out_bits_set        <= '0;
         io_out_bits_blockSelOH <= '0;
         io_out_bits_chosen     <= 2'd0;
         ptr                    <= 2'd2;
         lock                   <= 1'b0;
         lock_id                <= 2'd0;
      end else if (en) begin
         io_out_valid <= fire;
         if (fire) begin
            io_out_bits_set        <= sel_set;
            io_out_bits_blockSelOH <= sel_oh;
            io_out_bits_chosen     <= grant_id;
            ptr                    <= grant_id;
            lock                   <= ~sel_last;
            if (!sel_last) begin
               lock_id <= grant_id;
            end
         end
      end
   end

endmodule
